// File: rtl/mpsoc_ahb3_pkg.sv
// Shared AHB3-Lite encodings and the per-port state type for the multi-port scratchpad.
package mpsoc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } port_state_t;

  // Low address bits that must be zero for a naturally aligned transfer of this size.
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    case (size)
      HSIZE_BYTE:  return 3'b000;
      HSIZE_HWORD: return 3'b001;
      HSIZE_WORD:  return 3'b011;
      default:     return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mpsoc_ahb3_mpspram_if.sv
// Bundle of PORTS AHB3-Lite slave ports, one bit/lane group per port.
interface mpsoc_ahb3_mpspram_if #(
  parameter int PORTS = 4,
  parameter int PLEN  = 32,
  parameter int XLEN  = 32
);
  // Handshake: a transfer is accepted when HSEL & HREADY & HTRANS[1]; its data phase
  // ends on the first cycle with HREADYOUT=1, and HWDATA stays stable until then.
  logic [PORTS-1:0]           HSEL;
  logic [PORTS-1:0][PLEN-1:0] HADDR;
  logic [PORTS-1:0][XLEN-1:0] HWDATA;
  logic [PORTS-1:0]           HWRITE;
  logic [PORTS-1:0][2:0]      HSIZE;
  logic [PORTS-1:0][2:0]      HBURST;
  logic [PORTS-1:0][3:0]      HPROT;
  logic [PORTS-1:0][1:0]      HTRANS;
  logic [PORTS-1:0]           HMASTLOCK;
  logic [PORTS-1:0]           HREADY;
  logic [PORTS-1:0][XLEN-1:0] HRDATA;
  logic [PORTS-1:0]           HREADYOUT;
  logic [PORTS-1:0]           HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/mpsoc_spram_be.sv
// Single-port RAM with byte-lane write enables and a registered read port.
module mpsoc_spram_be #(
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [XLEN/8-1:0]            be,
  input  logic [XLEN-1:0]              wdata,
  output logic [XLEN-1:0]              rdata
);
  logic [XLEN-1:0] mem [MEM_DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < XLEN/8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mpsoc_ahb3_mpspram.sv
// Multi-port AHB3-Lite slave: one transfer queued per port, round-robin access to a shared SRAM.
module mpsoc_ahb3_mpspram
  import mpsoc_ahb3_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int PLEN      = 32,
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic                                         HCLK,
  input  logic                                         HRESETn,
  mpsoc_ahb3_mpspram_if.slave                          ahb,
  output logic [PORTS-1:0][2:0]                        dbg_state,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] dbg_rr_ptr
);
  localparam int LANES = XLEN / 8;
  localparam int ALSB  = $clog2(LANES);
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0] req, gnt, port_write;
  logic [AW-1:0]    port_widx [PORTS];
  logic [LANES-1:0] port_be   [PORTS];
  logic [PW-1:0]    ptr_q, ptr_d, gnt_idx;
  logic             found;
  logic [XLEN-1:0]  mem_rdata;

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    port_state_t          state_q, state_d;
    logic [AW+ALSB-1:0]   addr_q, addr_d;
    logic                 write_q, write_d;
    logic [1:0]           size_q, size_d;
    logic [XLEN-1:0]      hrdata_q, hrdata_d;
    logic                 accept, bad;
    logic [LANES-1:0]     be;

    always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      write_d  = write_q;
      size_d   = size_q;
      accept   = (state_q inside {ST_IDLE, ST_DONE, ST_ERR2}) & ahb.HSEL[p] & ahb.HREADY[p]
               & ((ahb.HTRANS[p] == HTRANS_NONSEQ) | (ahb.HTRANS[p] == HTRANS_SEQ));
      bad      = ((ahb.HADDR[p] >> ALSB) >= PLEN'(MEM_DEPTH))
               | (ahb.HSIZE[p] > 3'(ALSB))
               | (|(ahb.HADDR[p][2:0] & align_mask(ahb.HSIZE[p])));
      hrdata_d = (state_q == ST_DONE && !write_q) ? mem_rdata : hrdata_q;
      case (state_q)
        ST_WAIT: if (gnt[p]) state_d = ST_DONE;
        ST_ERR1: state_d = ST_ERR2;
        default: begin
          state_d = ST_IDLE;
          if (accept) begin
            state_d = bad ? ST_ERR1 : ST_WAIT;
            addr_d  = ahb.HADDR[p][AW+ALSB-1:0];
            write_d = ahb.HWRITE[p];
            size_d  = ahb.HSIZE[p][1:0];
          end
        end
      endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        state_q  <= ST_IDLE;
        addr_q   <= '0;
        write_q  <= 1'b0;
        size_q   <= '0;
        hrdata_q <= '0;
      end else begin
        state_q  <= state_d;
        addr_q   <= addr_d;
        write_q  <= write_d;
        size_q   <= size_d;
        hrdata_q <= hrdata_d;
      end
    end

    // A lane belongs to the transfer when it sits in the same 2^size block as the address.
    always_comb begin
      be = '0;
      for (int i = 0; i < LANES; i++) begin
        be[i] = ((i >> size_q) == (int'(addr_q[ALSB-1:0]) >> size_q));
      end
    end

    assign req[p]        = (state_q == ST_WAIT);
    assign port_write[p] = write_q;
    assign port_widx[p]  = addr_q[ALSB +: AW];
    assign port_be[p]    = be;
    assign dbg_state[p]  = state_q;

    assign ahb.HREADYOUT[p] = !(state_q inside {ST_WAIT, ST_ERR1});
    assign ahb.HRESP[p]     = (state_q inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    assign ahb.HRDATA[p]    = hrdata_d;
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    ptr_d   = ptr_q;
    for (int k = 0; k < PORTS; k++) begin
      if (!found && req[(int'(ptr_q) + k) % PORTS]) begin
        found   = 1'b1;
        gnt_idx = PW'((int'(ptr_q) + k) % PORTS);
      end
    end
    if (found) begin
      gnt[gnt_idx] = 1'b1;
      ptr_d        = (gnt_idx == PW'(PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign dbg_rr_ptr = ptr_q;

  mpsoc_spram_be #(
    .XLEN      (XLEN),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (HCLK),
    .en    (found),
    .we    (port_write[gnt_idx]),
    .addr  (port_widx[gnt_idx]),
    .be    (port_be[gnt_idx]),
    .wdata (ahb.HWDATA[gnt_idx]),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/mpsoc_ahb3_mpspram.md
Name: mpsoc_ahb3_mpspram

Overview:
Multi-port AHB3-Lite slave in front of one shared single-port SRAM. It replaces per-node private scratchpads in the 3D MPSoC, so several tiles or masters share one memory.
- Each of PORTS slave interfaces queues one transfer.
- A round-robin arbiter grants one port per cycle.
- Byte/halfword/word writes, synchronous reads.
- ERROR response for out-of-range, misaligned or oversize transfers.

Parameters:
PORTS, 4, number of AHB3 slave ports (1..16)
PLEN, 32, HADDR width
XLEN, 32, data width (32 or 64)
MEM_DEPTH, 256, memory depth in XLEN words; byte space is MEM_DEPTH*XLEN/8

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  [PORTS-1:0]  per-port select
HADDR  in  [PORTS-1:0][PLEN-1:0]  byte address
HWDATA  in  [PORTS-1:0][XLEN-1:0]  write data, valid in data phase
HWRITE  in  [PORTS-1:0]  1=write
HSIZE  in  [PORTS-1:0][2:0]  transfer size
HBURST  in  [PORTS-1:0][2:0]  ignored; each beat is handled independently
HPROT  in  [PORTS-1:0][3:0]  ignored
HTRANS  in  [PORTS-1:0][1:0]  IDLE/BUSY/NONSEQ/SEQ
HMASTLOCK  in  [PORTS-1:0]  ignored
HREADY  in  [PORTS-1:0]  bus ready for the port
HRDATA  out  [PORTS-1:0][XLEN-1:0]  read data
HREADYOUT  out  [PORTS-1:0]  slave ready
HRESP  out  [PORTS-1:0]  1=ERROR

Behaviour:
Reset (async, on HRESETn low):
- HREADYOUT=1, HRESP=0, HRDATA=0 on all ports.
- Port FSMs go to IDLE; round-robin pointer=0.
- No memory write is committed. Memory contents are not reset.

Address phase:
- A port accepts a transfer when HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ).
- On accept it latches addr, write and size.
- IDLE/BUSY transfers, or HSEL=0: zero-wait OKAY, FSM stays IDLE.

Validity check at accept. The transfer is an error if any of:
- word index HADDR>>log2(XLEN/8) >= MEM_DEPTH;
- HSIZE > log2(XLEN/8);
- HADDR not aligned to 2^HSIZE.
An error transfer goes to ERR1, otherwise to WAIT.

Port FSM:
- IDLE: HREADYOUT=1, HRESP=0.
- WAIT: HREADYOUT=0, HRESP=0. Raises a request to the arbiter. On grant, the memory op is issued and the FSM goes to DONE.
- DONE: HREADYOUT=1, HRESP=0. For reads, HRDATA = memory output. If a new transfer is accepted in this cycle, go to WAIT or ERR1; otherwise go to IDLE.
- ERR1: HREADYOUT=0, HRESP=1. Goes to ERR2 unconditionally.
- ERR2: HREADYOUT=1, HRESP=1. Then IDLE, or accept a new transfer as in DONE.

Latency:
- Uncontended transfer: address phase in cycle A, granted in A+1, completes in A+2 (exactly one wait state).
- Each cycle of contention adds one wait state.

Write path:
- HWDATA is sampled in the grant cycle; AHB holds it stable while HREADYOUT=0.
- Byte enables come from size and low address bits, little-endian lanes.
- The write commits at the grant clock edge.

Read path:
- Memory is read in the grant cycle; data is registered and presented in DONE.
- HRDATA keeps its last value outside DONE.

Arbiter:
- Round-robin among ports in WAIT, starting the search at the pointer.
- At most one grant per cycle.
- After a grant, pointer = granted+1 mod PORTS. With no request the pointer is unchanged.
- Ordering: a write granted before a read to the same word is visible to that read.

Error path:
- An error transfer never raises a request and never touches memory.

Decomposition:
- Shared package mpsoc_ahb3_pkg holds:
  - HTRANS codes (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HSIZE codes (BYTE=0, HWORD=1, WORD=2, DWORD=3);
  - HRESP_OKAY/ERROR;
  - a port-state enum.
- Sub-module mpsoc_spram_be: generic single-port RAM with byte enables, synchronous read, parameters XLEN and MEM_DEPTH.
- Per-port FSM and arbiter stay in the top module as a generate loop.

Test Plan:
1. Port0 writes word 0xDEADBEEF to 0x10, then reads 0x10. Each transfer shows HREADYOUT=0 for exactly 1 cycle; the read returns HRDATA=0xDEADBEEF, HRESP=0.
2. Port1 writes a byte to 0x13 with HWDATA=0xAB000000, then port0 reads 0x10. The read returns 0xABADBEEF.
3. Ports 0-3 issue NONSEQ reads of distinct words in the same cycle A, with pointer=0. Completions occur at A+2, A+3, A+4, A+5 in order 0,1,2,3; afterwards pointer=0.
4. Write to 0x400 (word 256 >= MEM_DEPTH). Port shows HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; a subsequent read of 0x0 is unchanged.
5. Halfword access at 0x11, and HSIZE=3 with XLEN=32. Both give the two-cycle ERROR response and no memory access.
6. HRESETn asserted while port2 is in WAIT with a write pending. All outputs take reset values immediately; the target word keeps its old value after reset.
